// File: rtl/struct_pkg.sv
// rtl/struct_pkg.sv - shared record types, sync default and receiver state enum
package struct_pkg;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   typedef logic [7:0] t_t;

   typedef struct packed {
      byte a;
      byte b;
   } p_t;

   typedef struct packed {
      bit         a;
      logic [7:0] b;
      t_t         t;
      p_t         ps;
   } s_t;

   typedef enum logic [2:0] {
      HUNT,
      FLAGS,
      B,
      T,
      PSA,
      PSB,
      CSUM,
      HOLD
   } rx_state_e;

endpackage

// File: rtl/struct_frame_csum.sv
// rtl/struct_frame_csum.sv - 8-bit XOR accumulator with clear and enable
module struct_frame_csum (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 8'h00;
      end else if (clr) begin
         acc <= 8'h00;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/struct_frame_rx.sv
// rtl/struct_frame_rx.sv - framed byte-stream receiver delivering one s_t per good frame
module struct_frame_rx
   import struct_pkg::*;
#(
   parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output s_t         out_rec,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err_flags,
   output logic       err_csum,
   output logic [7:0] drop_cnt
);

   rx_state_e  state;
   rx_state_e  state_nxt;
   s_t         rec;
   logic       flags_bad;
   logic       take;
   logic       csum_clr;
   logic       csum_en;
   logic [7:0] csum_acc;

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_rec   = rec;
   assign take      = in_valid && in_ready;

   struct_frame_csum u_csum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (csum_clr),
      .en    (csum_en),
      .din   (in_data),
      .acc   (csum_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      csum_clr  = 1'b0;
      csum_en   = 1'b0;
      case (state)
         HUNT: begin
            if (take && in_data == SYNC) begin
               state_nxt = FLAGS;
               csum_clr  = 1'b1;
            end
         end
         FLAGS: if (take) begin state_nxt = B;   csum_en = 1'b1; end
         B:     if (take) begin state_nxt = T;   csum_en = 1'b1; end
         T:     if (take) begin state_nxt = PSA; csum_en = 1'b1; end
         PSA:   if (take) begin state_nxt = PSB; csum_en = 1'b1; end
         PSB:   if (take) begin state_nxt = CSUM; csum_en = 1'b1; end
         CSUM: begin
            if (take) begin
               state_nxt = (flags_bad || csum_acc != in_data) ? HUNT : HOLD;
            end
         end
         HOLD: if (out_ready) state_nxt = HUNT;
         default: state_nxt = HUNT;
      endcase
   end

   // Record fields and error pulses; a bad flags byte masks any checksum error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec       <= '0;
         flags_bad <= 1'b0;
         err_flags <= 1'b0;
         err_csum  <= 1'b0;
         drop_cnt  <= 8'h00;
      end else begin
         err_flags <= 1'b0;
         err_csum  <= 1'b0;
         if (take) begin
            case (state)
               HUNT: begin
                  if (in_data != SYNC && drop_cnt != 8'hFF) begin
                     drop_cnt <= drop_cnt + 8'h01;
                  end
               end
               FLAGS: begin
                  rec.a     <= in_data[0];
                  flags_bad <= |in_data[7:1];
               end
               B:    rec.b    <= in_data;
               T:    rec.t    <= in_data;
               PSA:  rec.ps.a <= in_data;
               PSB:  rec.ps.b <= in_data;
               CSUM: begin
                  if (flags_bad) begin
                     err_flags <= 1'b1;
                  end else if (csum_acc != in_data) begin
                     err_csum <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_struct_frame_rx.sv
// tb/tb_struct_frame_rx.sv - randomized self-checking bench for struct_frame_rx
module tb_struct_frame_rx;
   import struct_pkg::*;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   s_t         out_rec;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       err_flags;
   logic       err_csum;
   logic [7:0] drop_cnt;

   always #5 clk = ~clk;

   struct_frame_rx #(.SYNC(SYNC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_rec   (out_rec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_flags (err_flags),
      .err_csum  (err_csum),
      .drop_cnt  (drop_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame is SYNC then six bytes gathered in a queue.
   bit          m_hold = 1'b0;
   bit          m_coll = 1'b0;
   bit          m_ef = 1'b0;
   bit          m_ec = 1'b0;
   logic [7:0]  m_frm[$];
   logic [32:0] m_rec = '0;
   logic [7:0]  m_x;
   int          m_drop = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold = 1'b0; m_coll = 1'b0; m_ef = 1'b0; m_ec = 1'b0;
         m_frm.delete(); m_rec = '0; m_drop = 0;
      end else begin
         m_ef = 1'b0;
         m_ec = 1'b0;
         if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
         end else if (in_valid) begin
            if (!m_coll) begin
               if (in_data == SYNC) begin
                  m_coll = 1'b1;
                  m_frm.delete();
               end else if (m_drop < 255) begin
                  m_drop++;
               end
            end else begin
               m_frm.push_back(in_data);
               if (m_frm.size() == 6) begin
                  m_coll = 1'b0;
                  m_x = m_frm[0] ^ m_frm[1] ^ m_frm[2] ^ m_frm[3] ^ m_frm[4];
                  if (m_frm[0][7:1] != 7'd0) m_ef = 1'b1;
                  else if (m_x != m_frm[5]) m_ec = 1'b1;
                  else begin
                     m_hold = 1'b1;
                     m_rec  = {m_frm[0][0], m_frm[1], m_frm[2], m_frm[3], m_frm[4]};
                  end
               end
            end
         end
      end
   end

   bit          chk_on = 1'b0;
   int          n_ef = 0, n_ec = 0, n_vc = 0, n_rec = 0;
   logic [32:0] last_rec = '0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready", in_ready, !m_hold);
         chk("out_valid", out_valid, m_hold);
         if (m_hold) chk("out_rec", out_rec, m_rec);
         chk("err_flags", err_flags, m_ef);
         chk("err_csum", err_csum, m_ec);
         chk("drop_cnt", drop_cnt, m_drop[7:0]);
         if (err_flags) n_ef++;
         if (err_csum) n_ec++;
         if (out_valid) n_vc++;
         if (out_valid && out_ready) begin
            n_rec++;
            last_rec = out_rec;
         end
      end
   end

   bit rnd_rdy = 1'b0;
   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1 out_ready = 1'($urandom_range(1));
      end
   end

   logic [7:0] tx_q[$];
   int         acc_wait = 0;

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      bit acc;
      while ($urandom_range(99) < gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      acc_wait = n;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", b, n);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_q(input int gap);
      while (tx_q.size() > 0) send_byte(tx_q.pop_front(), gap);
   endtask

   task automatic mk_frame(input logic [7:0] fl, b, t, pa, pb, cs);
      tx_q.push_back(SYNC);
      tx_q.push_back(fl); tx_q.push_back(b); tx_q.push_back(t);
      tx_q.push_back(pa); tx_q.push_back(pb); tx_q.push_back(cs);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_rec"}, out_rec, 33'h0);
      chk({tag, "_errs"}, {err_flags, err_csum}, 2'b00);
      chk({tag, "_drop"}, drop_cnt, 8'h00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [32:0] held;
      logic [7:0]  fl, b, t, pa, pb, cs, j;
      int          kind;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n  = 1'b1;
      chk_on = 1'b1;

      out_ready = 1'b1;
      mk_frame(8'h01, 8'hFF, 8'h55, 8'hAA, 8'h55, 8'h54);
      send_q(0);
      idle(3);
      chk("good_n_rec", n_rec, 1);
      chk("good_rec", last_rec, 33'h1_FF55_AA55);
      chk("good_model_rec", m_rec, 33'h1_FF55_AA55);
      chk("good_valid_cycles", n_vc, 1);
      chk("good_no_err", n_ef + n_ec, 0);

      mk_frame(8'h01, 8'hFF, 8'h55, 8'hAA, 8'h55, 8'h55);
      mk_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09);
      send_q(0);
      idle(3);
      chk("badcs_err_csum", n_ec, 1);
      chk("badcs_err_flags", n_ef, 0);
      chk("badcs_n_rec", n_rec, 2);
      chk("after_badcs_rec", last_rec, 33'h1_1234_5678);

      mk_frame(8'h03, 8'hFF, 8'h55, 8'hAA, 8'h55, 8'h56);
      send_q(0);
      idle(3);
      chk("badfl_err_flags", n_ef, 1);
      chk("badfl_no_err_csum", n_ec, 1);
      chk("badfl_n_rec", n_rec, 2);

      tx_q.push_back(8'h00); tx_q.push_back(8'h11);
      mk_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      send_q(0);
      idle(3);
      chk("hunt_drop", drop_cnt, 8'd2);
      chk("zero_n_rec", n_rec, 3);
      chk("zero_rec", last_rec, 33'h0);

      out_ready = 1'b0;
      mk_frame(8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
      send_q(0);
      @(negedge clk);
      held = out_rec;
      chk("stall_rec", held, 33'h0_DEAD_BEEF);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_stable", out_rec, held);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_byte(SYNC, 0);
      chk("sync_after_hold", acc_wait, 2);
      tx_q = '{8'h01, 8'hFF, 8'h55, 8'hAA, 8'h55, 8'h54};
      send_q(0);
      idle(3);
      chk("stall_n_rec", n_rec, 5);
      chk("after_stall_rec", last_rec, 33'h1_FF55_AA55);

      tx_q = '{SYNC, 8'h01, 8'hFF, 8'h55};
      send_q(0);
      rst_n = 1'b0;
      #2;
      chk_reset_outputs("midreset");
      idle(2);
      rst_n = 1'b1;
      mk_frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
      send_q(30);
      idle(3);
      chk("fresh_rec", last_rec, 33'h0_0102_0304);

      repeat (300) begin
         j = 8'($urandom);
         if (j == SYNC) j = 8'h00;
         tx_q.push_back(j);
      end
      send_q(0);
      idle(2);
      chk("drop_saturate", drop_cnt, 8'd255);
      chk("model_drop_saturate", m_drop, 255);

      rnd_rdy = 1'b1;
      repeat (60) begin
         repeat ($urandom_range(2)) tx_q.push_back(8'h3C);
         fl = {7'd0, 1'($urandom_range(1))};
         b  = ($urandom_range(3) == 0) ? SYNC : 8'($urandom);
         t  = 8'($urandom);
         pa = 8'($urandom);
         pb = 8'($urandom);
         cs = fl ^ b ^ t ^ pa ^ pb;
         kind = $urandom_range(9);
         if (kind == 0) cs = cs ^ 8'($urandom_range(255, 1));
         if (kind == 1) fl = {7'($urandom_range(127, 1)), fl[0]};
         mk_frame(fl, b, t, pa, pb, cs);
         send_q($urandom_range(40));
      end
      rnd_rdy = 1'b0;
      idle(2);
      out_ready = 1'b1;
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
